// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device byte transmitter with clock filter, ACK check and timeout
module ps2_host_tx #(
   parameter int T_INHIBIT = 5000,
   parameter int T_TIMEOUT = 750000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] dato_tx,
   input  logic       iniciar,
   input  logic       ps2c_in,
   input  logic       ps2d_in,
   output logic       ps2c_oe,
   output logic       ps2d_oe,
   output logic       ocupado,
   output logic       tx_listo,
   output logic       error_tx
);

   localparam int INH_W = $clog2(T_INHIBIT + 1);
   localparam int TO_W  = $clog2(T_TIMEOUT + 1);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(T_INHIBIT - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(T_TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_RTS, S_BITS, S_ACK} state_t;

   state_t           state_q, state_d;
   logic             c_meta_q, c_sync_q, d_meta_q, d_sync_q;
   logic [7:0]       sh_q, sh_d;
   logic             filt_q, filt_d;
   logic             fall_q;
   logic [7:0]       byte_q, byte_d;
   logic             par_q, par_d;
   logic [3:0]       n_q, n_d;
   logic             drv_q, drv_d;       // value placed on the data line, 1 = released
   logic [INH_W-1:0] inh_q, inh_d;
   logic [TO_W-1:0]  to_q, to_d;
   logic             tx_listo_q, tx_listo_d;
   logic             error_q, error_d;

   // Clock filter: level changes only after 8 identical synchronized samples
   always_comb begin
      sh_d   = {sh_q[6:0], c_sync_q};
      filt_d = filt_q;
      if (sh_d == 8'h00) begin
         filt_d = 1'b0;
      end else if (sh_d == 8'hFF) begin
         filt_d = 1'b1;
      end
   end

   // Line synchronizers, filter history and falling-edge strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         c_meta_q <= 1'b1;
         c_sync_q <= 1'b1;
         d_meta_q <= 1'b1;
         d_sync_q <= 1'b1;
         sh_q     <= 8'hFF;
         filt_q   <= 1'b1;
         fall_q   <= 1'b0;
      end else begin
         c_meta_q <= ps2c_in;
         c_sync_q <= c_meta_q;
         d_meta_q <= ps2d_in;
         d_sync_q <= d_meta_q;
         sh_q     <= sh_d;
         filt_q   <= filt_d;
         fall_q   <= filt_q & ~filt_d;
      end
   end

   // Transfer state, counters and result pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         byte_q     <= 8'h00;
         par_q      <= 1'b0;
         n_q        <= 4'd0;
         drv_q      <= 1'b1;
         inh_q      <= '0;
         to_q       <= '0;
         tx_listo_q <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_q     <= byte_d;
         par_q      <= par_d;
         n_q        <= n_d;
         drv_q      <= drv_d;
         inh_q      <= inh_d;
         to_q       <= to_d;
         tx_listo_q <= tx_listo_d;
         error_q    <= error_d;
      end
   end

   // Next-state and line drive; a fall wins over a coincident timeout
   always_comb begin
      state_d    = state_q;
      byte_d     = byte_q;
      par_d      = par_q;
      n_d        = n_q;
      drv_d      = drv_q;
      inh_d      = inh_q;
      to_d       = to_q;
      tx_listo_d = 1'b0;
      error_d    = 1'b0;
      ps2c_oe    = 1'b0;
      ps2d_oe    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (iniciar) begin
               byte_d  = dato_tx;
               par_d   = ~^dato_tx;
               n_d     = 4'd0;
               drv_d   = 1'b1;
               inh_d   = '0;
               to_d    = '0;
               state_d = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            ps2c_oe = 1'b1;
            if (inh_q == INH_LAST) begin
               to_d    = '0;
               state_d = S_RTS;
            end else begin
               inh_d = inh_q + INH_W'(1);
            end
         end
         S_RTS: begin
            ps2d_oe = 1'b1;
            if (fall_q) begin
               n_d     = 4'd1;
               drv_d   = byte_q[0];
               to_d    = '0;
               state_d = S_BITS;
            end else if (to_q == TO_LAST) begin
               error_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         S_BITS: begin
            ps2d_oe = ~drv_q;
            if (fall_q) begin
               n_d  = n_q + 4'd1;
               to_d = '0;
               if (n_q < 4'd8) begin
                  drv_d = byte_q[n_q[2:0]];
               end else if (n_q == 4'd8) begin
                  drv_d = par_q;
               end else begin
                  drv_d   = 1'b1;
                  state_d = S_ACK;
               end
            end else if (to_q == TO_LAST) begin
               error_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         S_ACK: begin
            if (fall_q) begin
               n_d     = 4'd11;
               state_d = S_IDLE;
               if (!d_sync_q) begin
                  tx_listo_d = 1'b1;
               end else begin
                  error_d = 1'b1;
               end
            end else if (to_q == TO_LAST) begin
               error_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign ocupado  = (state_q != S_IDLE);
   assign tx_listo = tx_listo_q;
   assign error_tx = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

   localparam int T_INH = 5000;
   localparam int T_TO  = 3000;
   localparam int HALF  = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] dato_tx = 8'h00;
   logic       iniciar = 1'b0;
   logic       ps2c_in = 1'b1;
   logic       ps2d_in = 1'b1;
   logic       ps2c_oe, ps2d_oe, ocupado, tx_listo, error_tx;

   int passed = 0;
   int total  = 0;
   int tx_seen = 0;
   int err_seen = 0;
   int viol = 0;

   ps2_host_tx #(.T_INHIBIT(T_INH), .T_TIMEOUT(T_TO)) dut (
      .clk(clk), .rst(rst), .dato_tx(dato_tx), .iniciar(iniciar),
      .ps2c_in(ps2c_in), .ps2d_in(ps2d_in), .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe),
      .ocupado(ocupado), .tx_listo(tx_listo), .error_tx(error_tx)
   );

   always #5 clk = ~clk;

   // Pulse monitor: counts result pulses and flags overlap or pulses while busy
   always @(negedge clk) begin
      if (tx_listo) tx_seen++;
      if (error_tx) err_seen++;
      if ((tx_listo && error_tx) || ((tx_listo || error_tx) && ocupado)) viol++;
   end

   task automatic start_tx(input logic [7:0] b);
      dato_tx = b;
      iniciar = 1'b1;
      @(negedge clk);
      iniciar = 1'b0;
   endtask

   // Device model: waits for request-to-send, then clocks n_edges falls,
   // recording the data line seen during the low phase of edges 1..10
   task automatic device_frame(input int n_edges, input logic ack, input logic glitch,
                               output logic [9:0] seen, output logic timed_out);
      int k;
      seen = '0;
      timed_out = 1'b0;
      k = 0;
      while (!(ps2c_oe === 1'b0 && ps2d_oe === 1'b1) && k < 20000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 20000) begin
         timed_out = 1'b1;
         return;
      end
      repeat (HALF) @(negedge clk);
      for (int e = 1; e <= n_edges; e++) begin
         if (e == 11) ps2d_in = ack;
         ps2c_in = 1'b0;
         repeat (HALF) @(negedge clk);
         if (e <= 10) seen[e-1] = ~ps2d_oe;
         ps2c_in = 1'b1;
         if (glitch && e < 10) begin
            repeat (20) @(negedge clk);
            ps2c_in = 1'b0;
            repeat (3) @(negedge clk);
            ps2c_in = 1'b1;
            if (e == 5) begin
               dato_tx = 8'h55;
               iniciar = 1'b1;
               @(negedge clk);
               iniciar = 1'b0;
            end
            repeat (15) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
         if (e == 11) ps2d_in = 1'b1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (4) @(negedge clk);
      total++; if (ps2c_oe !== 1'b0) $display("FAIL reset_ps2c_oe got=%b exp=0", ps2c_oe); else passed++;
      total++; if (ps2d_oe !== 1'b0) $display("FAIL reset_ps2d_oe got=%b exp=0", ps2d_oe); else passed++;
      total++; if (ocupado !== 1'b0) $display("FAIL reset_ocupado got=%b exp=0", ocupado); else passed++;
      total++; if (tx_listo !== 1'b0) $display("FAIL reset_tx_listo got=%b exp=0", tx_listo); else passed++;
      total++; if (error_tx !== 1'b0) $display("FAIL reset_error_tx got=%b exp=0", error_tx); else passed++;
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_ed;
      int cnt, tx0, er0;
      logic [9:0] seen;
      logic to;
      tx0 = tx_seen; er0 = err_seen;
      start_tx(8'hED);
      total++; if (ocupado !== 1'b1) $display("FAIL ed_ocupado got=%b exp=1", ocupado); else passed++;
      cnt = 0;
      while (ps2c_oe === 1'b1 && cnt < 10000) begin
         cnt++;
         @(negedge clk);
      end
      total++; if (cnt != T_INH) $display("FAIL ed_inhibit_len got=%0d exp=%0d", cnt, T_INH); else passed++;
      device_frame(11, 1'b0, 1'b0, seen, to);
      repeat (20) @(negedge clk);
      total++; if (to !== 1'b0) $display("FAIL ed_rts_wait got=timeout exp=rts"); else passed++;
      total++; if (seen !== 10'h3ED) $display("FAIL ed_bits got=%h exp=3ed", seen); else passed++;
      total++; if (tx_seen - tx0 != 1) $display("FAIL ed_tx_listo got=%0d exp=1", tx_seen - tx0); else passed++;
      total++; if (err_seen - er0 != 0) $display("FAIL ed_error_tx got=%0d exp=0", err_seen - er0); else passed++;
      total++; if ({ocupado, ps2c_oe, ps2d_oe} !== 3'b000) $display("FAIL ed_idle got=%b exp=000", {ocupado, ps2c_oe, ps2d_oe}); else passed++;
   endtask

   task automatic test_parity;
      logic [9:0] seen;
      logic to;
      start_tx(8'h00);
      device_frame(11, 1'b0, 1'b0, seen, to);
      repeat (20) @(negedge clk);
      total++; if (seen !== 10'h300) $display("FAIL parity_00 got=%h exp=300", seen); else passed++;
      start_tx(8'h01);
      device_frame(11, 1'b0, 1'b0, seen, to);
      repeat (20) @(negedge clk);
      total++; if (seen !== 10'h201) $display("FAIL parity_01 got=%h exp=201", seen); else passed++;
   endtask

   task automatic test_ack_error;
      int tx0, er0;
      logic [9:0] seen;
      logic to;
      tx0 = tx_seen; er0 = err_seen;
      start_tx(8'hED);
      device_frame(11, 1'b1, 1'b0, seen, to);
      repeat (20) @(negedge clk);
      total++; if (err_seen - er0 != 1) $display("FAIL nack_error_tx got=%0d exp=1", err_seen - er0); else passed++;
      total++; if (tx_seen - tx0 != 0) $display("FAIL nack_tx_listo got=%0d exp=0", tx_seen - tx0); else passed++;
      total++; if ({ocupado, ps2c_oe, ps2d_oe} !== 3'b000) $display("FAIL nack_idle got=%b exp=000", {ocupado, ps2c_oe, ps2d_oe}); else passed++;
   endtask

   task automatic test_timeout;
      int cnt, k, tx0;
      logic prev;
      logic [9:0] seen;
      logic to;
      tx0 = tx_seen;
      start_tx(8'h08);
      device_frame(3, 1'b0, 1'b0, seen, to);
      prev = ps2d_oe;
      ps2c_in = 1'b0;
      k = 0;
      while (ps2d_oe === prev && k < 200) begin
         @(negedge clk);
         k++;
      end
      total++; if (k >= 200) $display("FAIL timeout_edge4 got=no_change exp=bit3_driven"); else passed++;
      cnt = 0;
      while (error_tx !== 1'b1 && cnt < 2 * T_TO) begin
         @(negedge clk);
         cnt++;
      end
      total++; if (cnt != T_TO) $display("FAIL timeout_delay got=%0d exp=%0d", cnt, T_TO); else passed++;
      total++; if ({ps2c_oe, ps2d_oe} !== 2'b00) $display("FAIL timeout_lines got=%b exp=00", {ps2c_oe, ps2d_oe}); else passed++;
      ps2c_in = 1'b1;
      repeat (20) @(negedge clk);
      total++; if (tx_seen - tx0 != 0) $display("FAIL timeout_tx_listo got=%0d exp=0", tx_seen - tx0); else passed++;
   endtask

   task automatic test_reset_mid;
      int tx0, er0;
      logic [9:0] seen;
      logic to;
      tx0 = tx_seen; er0 = err_seen;
      start_tx(8'hED);
      device_frame(6, 1'b0, 1'b0, seen, to);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if ({ocupado, ps2c_oe, ps2d_oe} !== 3'b000) $display("FAIL rstmid_idle got=%b exp=000", {ocupado, ps2c_oe, ps2d_oe}); else passed++;
      repeat (30) @(negedge clk);
      total++; if ((tx_seen - tx0) + (err_seen - er0) != 0) $display("FAIL rstmid_pulses got=%0d exp=0", (tx_seen - tx0) + (err_seen - er0)); else passed++;
      start_tx(8'hF4);
      device_frame(11, 1'b0, 1'b0, seen, to);
      repeat (20) @(negedge clk);
      total++; if (seen !== 10'h2F4) $display("FAIL rstmid_f4_bits got=%h exp=2f4", seen); else passed++;
      total++; if (tx_seen - tx0 != 1) $display("FAIL rstmid_f4_tx_listo got=%0d exp=1", tx_seen - tx0); else passed++;
   endtask

   task automatic test_glitch_busy;
      int tx0;
      logic [9:0] seen;
      logic to;
      tx0 = tx_seen;
      start_tx(8'hED);
      device_frame(11, 1'b0, 1'b1, seen, to);
      repeat (20) @(negedge clk);
      total++; if (seen !== 10'h3ED) $display("FAIL glitch_bits got=%h exp=3ed", seen); else passed++;
      total++; if (tx_seen - tx0 != 1) $display("FAIL glitch_tx_listo got=%0d exp=1", tx_seen - tx0); else passed++;
      total++; if (ocupado !== 1'b0) $display("FAIL glitch_restart got=%b exp=0", ocupado); else passed++;
   endtask

   initial begin
      test_reset;
      test_ed;
      test_parity;
      test_ack_error;
      test_timeout;
      test_reset_mid;
      test_glitch_busy;
      total++; if (viol != 0) $display("FAIL pulse_rules got=%0d exp=0", viol); else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter T_INHIBIT, default 5000, clock cycles ps2c is held low before request-to-send (100 us at 50 MHz).
REQ-002 Parameter T_TIMEOUT, default 750000, max clock cycles between device clock falling edges before abort (15 ms at 50 MHz).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 dato_tx  input  8  byte to send to keyboard (e.g. 0xED, LED mask); captured on accepted start.
REQ-006 iniciar  input  1  start request, one-cycle pulse.
REQ-007 ps2c_in  input  1  sampled PS/2 clock line (asynchronous to clk).
REQ-008 ps2d_in  input  1  sampled PS/2 data line.
REQ-009 ps2c_oe  output  1  1 = pull PS/2 clock low, 0 = release (open drain).
REQ-010 ps2d_oe  output  1  1 = pull PS/2 data low, 0 = release.
REQ-011 ocupado  output  1  high from accepted start until return to IDLE.
REQ-012 tx_listo  output  1  one-cycle pulse, byte sent and ACK = 0 received.
REQ-013 error_tx  output  1  one-cycle pulse, ACK missing (ACK = 1) or timeout.

Function
REQ-014 ps2c_in SHALL pass a 2-flop synchronizer, then an 8-sample filter: filtered clock goes 0 after 8 consecutive 0 samples, 1 after 8 consecutive 1 samples, otherwise holds; filtered reset value 1.
REQ-015 A falling edge (fall) SHALL be a one-cycle strobe when filtered clock changes 1 -> 0.
REQ-016 States: IDLE, INHIBIT, RTS, BITS, ACK; ocupado = (state != IDLE).
REQ-017 IDLE: ps2c_oe = 0, ps2d_oe = 0; iniciar = 1 -> latch dato_tx, compute odd parity (parity = ~^dato_tx), clear counters, go INHIBIT next cycle.
REQ-018 iniciar SHALL be ignored when not in IDLE; the latched byte SHALL not change mid-transfer.
REQ-019 INHIBIT: ps2c_oe = 1, ps2d_oe = 0 for exactly T_INHIBIT cycles; on final cycle go RTS.
REQ-020 RTS: ps2c_oe = 0, ps2d_oe = 1 (start bit 0); timeout counter starts; on fall go BITS with edge count n = 1.
REQ-021 BITS: on fall number n, drive for n = 1..8 data bit n-1 (LSB first), n = 9 parity, n = 10 stop (released); ps2d_oe = inverse of driven bit; ps2c_oe = 0 throughout.
REQ-022 Driven value SHALL update in the cycle after the fall strobe and hold until the next fall.
REQ-023 After n = 10 is driven, next fall (11th) SHALL sample synchronized ps2d_in: 0 -> tx_listo pulse, 1 -> error_tx pulse; both cases go IDLE with lines released.
REQ-024 ACK state covers the wait for the 11th fall; ps2d_oe = 0 in ACK.
REQ-025 Timeout counter SHALL clear on entry to RTS and on every fall; reaching T_TIMEOUT in RTS, BITS or ACK SHALL pulse error_tx, release both lines, go IDLE.
REQ-026 tx_listo and error_tx SHALL be mutually exclusive and never high outside the cycle of return to IDLE.
REQ-027 A fall in IDLE or INHIBIT SHALL be ignored (no count, no state change).
REQ-028 iniciar coincident with return to IDLE SHALL be ignored; a new start requires IDLE on the sampling edge.
REQ-029 Counters SHALL be sized to hold T_INHIBIT and T_TIMEOUT without wrap; n is 4 bits, never exceeds 11.

Reset
REQ-030 rst = 1 at a clock edge SHALL force IDLE, ps2c_oe = 0, ps2d_oe = 0, ocupado = 0, tx_listo = 0, error_tx = 0, counters 0, filter and synchronizers to 1, from any state including mid-transfer.
REQ-031 No pulse SHALL be emitted for a transfer aborted by reset.

Verification
REQ-032 dato_tx = 0xED, iniciar pulse, device model clocks 11 edges with ACK = 0 -> ps2c_oe high 5000 cycles, data bits 1,0,1,1,0,1,1,1, parity 1, stop released, single tx_listo pulse.
REQ-033 dato_tx = 0x00 -> parity bit 1 driven at edge 9 (ps2d_oe = 0); dato_tx = 0x01 -> parity 0 (ps2d_oe = 1).
REQ-034 Device model returns ACK = 1 -> error_tx single pulse, no tx_listo, IDLE, lines released.
REQ-035 Device stops clocking after edge 4 -> error_tx exactly T_TIMEOUT cycles after edge 4, both oe = 0.
REQ-036 rst asserted after edge 6 -> next cycle IDLE, both oe = 0, no pulses; subsequent iniciar with 0xF4 completes normally.
REQ-037 iniciar pulsed during BITS with different dato_tx, plus 3-cycle glitches on ps2c_in -> original byte sent unchanged, glitches produce no fall.
